// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NREQ requesters.
//
// One {op,a,b} command is accepted at a time under round-robin priority. The
// command drives the ALU for exactly one cycle (EXEC). The ALU outputs are
// registered, then presented to the winning requester (RESP) until it accepts.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req_valid/ready     per-requester command handshake (ready one-hot or zero)
//   req_op/a/b          packed per-requester command fields
//   resp_valid/ready    per-requester response handshake (valid one-hot)
//   resp_result/cf/of   registered ALU result and flags
//   alu_num1/num2/op    to the ALU, non-zero only in EXEC
//   alu_result/cf/overflow  from the ALU
//
// Optional feature, enabled by defining ALU_ARB_STATS_EN:
//   stat_clr            synchronous clear of the grant counters
//   stat_grants         one saturating 8-bit grant counter per requester

module alu_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      resp_result,
  output logic              resp_cf,
  output logic              resp_of,
  output logic [W-1:0]      alu_num1,
  output logic [W-1:0]      alu_num2,
  output logic [2:0]        alu_op,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_cf,
  input  logic              alu_overflow
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [8*NREQ-1:0] stat_grants
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          cf_q, cf_d;
  logic          of_q, of_d;

  logic [IW-1:0] arb_idx;
  logic [IW-1:0] cand_idx;
  logic          arb_found;
  logic          accept;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_idx = IW'((32'(rr_ptr_q) + k) % NREQ);
      if (!arb_found && req_valid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign accept = (state_q == StIdle) && arb_found;

  // rst_n gates ready so nothing looks accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (accept && rst_n) begin
      req_ready[arb_idx] = 1'b1;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == StResp) begin
      resp_valid[gnt_q] = 1'b1;
    end
  end

  always_comb begin
    alu_num1 = '0;
    alu_num2 = '0;
    alu_op   = '0;
    if (state_q == StExec) begin
      alu_num1 = a_q;
      alu_num2 = b_q;
      alu_op   = op_q;
    end
  end

  assign resp_result = result_q;
  assign resp_cf     = cf_q;
  assign resp_of     = of_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cf_d     = cf_q;
    of_d     = of_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          gnt_d   = arb_idx;
          op_d    = req_op[32'(arb_idx) * 3 +: 3];
          a_d     = req_a[32'(arb_idx) * W +: W];
          b_d     = req_b[32'(arb_idx) * W +: W];
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = alu_result;
        cf_d     = alu_cf;
        of_d     = alu_overflow;
        state_d  = StResp;
      end
      StResp: begin
        if (resp_ready[gnt_q]) begin
          rr_ptr_d = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [8*NREQ-1:0] stat_q, stat_d;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    stat_d = stat_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (stat_clr) begin
        stat_d[8*i +: 8] = 8'h00;
      end else if (accept && (arb_idx == IW'(i)) && (stat_q[8*i +: 8] != 8'hFF)) begin
        stat_d[8*i +: 8] = stat_q[8*i +: 8] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_grants = stat_q;
`endif

endmodule
